// File: rtl/hpm_counter_unit.sv
// ---------------------------------------------------------------------------
// hpm_counter_unit
//
// Hardware performance-monitor block. It holds NUM_CNT+2 counters of CNT_W
// bits each:
//   index 0                 : cycle counter   (+1 per active cycle)
//   index 1                 : instret counter (+retire_cnt per active cycle)
//   index 2 .. NUM_CNT+1    : programmable counters; each adds 1 when the
//                             event line picked by its SEL register is high
// Software reaches the unit through a simple 32-bit word-addressed CSR bus.
// The bus supports per-counter inhibit, sticky overflow status with an
// interrupt, freeze-on-overflow, and a hi-word shadow so that a lo-then-hi
// read pair of one counter is always consistent.
//
// Ports
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   retire_cnt  in   [RET_W]   instructions retired this cycle
//   event_vec   in   [NUM_EVT] per-cycle event pulses
//   csr_we      in   write strobe
//   csr_re      in   read strobe
//   csr_addr    in   [8]  word address
//   csr_wdata   in   [32] write data
//   csr_rdata   out  [32] read data, valid one cycle after csr_re
//   csr_rvalid  out  one-cycle pulse qualifying csr_rdata
//   ovf_irq     out  registered |(OVF & IE)
// ---------------------------------------------------------------------------
module hpm_counter_unit #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 48,
    parameter int NUM_EVT = 32,
    parameter int RET_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RET_W-1:0]   retire_cnt,
    input  logic [NUM_EVT-1:0] event_vec,
    input  logic               csr_we,
    input  logic               csr_re,
    input  logic [7:0]         csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_rvalid,
    output logic               ovf_irq
);

    localparam int TOT   = NUM_CNT + 2;
    localparam int HI_W  = CNT_W - 32;
    localparam int TAG_W = 5;

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_INHIBIT = 8'h01;
    localparam logic [7:0] ADDR_OVF     = 8'h02;
    localparam logic [7:0] ADDR_IE      = 8'h03;

    // Control / status state
    logic             en_q, en_d;
    logic             frz_q, frz_d;
    logic [TOT-1:0]   inhibit_q, inhibit_d;
    logic [TOT-1:0]   ovf_q, ovf_d;
    logic [TOT-1:0]   ie_q, ie_d;
    logic [7:0]       sel_q [NUM_CNT];
    logic [7:0]       sel_d [NUM_CNT];

    // Hi-word shadow for atomic 64-bit reads
    logic [HI_W-1:0]  shadow_q, shadow_d;
    logic [TAG_W-1:0] shadow_tag_q, shadow_tag_d;
    logic             shadow_valid_q, shadow_valid_d;

    // Read response and interrupt
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             irq_q, irq_d;

    // Per-counter views shared between the counter slices and the CSR logic
    logic [TOT-1:0][CNT_W-1:0] cnt_all;
    logic [TOT-1:0]            cnt_wr;
    logic [TOT-1:0]            carry;

    // Event lines padded to the full 8-bit SEL range so that any SEL value
    // can index safely; out-of-range selects land on a constant zero.
    logic [255:0] ev_ext;

    always_comb begin
        ev_ext                = '0;
        ev_ext[NUM_EVT-1:0]   = event_vec;
    end

    // -----------------------------------------------------------------------
    // Counter slices
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < TOT; gi++) begin : g_cnt
            localparam logic [7:0] LO_ADDR = 8'(16 + 2 * gi);
            localparam logic [7:0] HI_ADDR = 8'(17 + 2 * gi);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] inc;
            logic [CNT_W:0]   sum;
            logic             wr_lo, wr_hi, active;

            if (gi == 0) begin : g_cycle
                assign inc = CNT_W'(1);
            end else if (gi == 1) begin : g_instret
                assign inc = CNT_W'(retire_cnt);
            end else begin : g_prog
                assign inc = CNT_W'(ev_ext[sel_q[gi-2]]);
            end

            assign wr_lo  = csr_we && (csr_addr == LO_ADDR);
            assign wr_hi  = csr_we && (csr_addr == HI_ADDR);
            assign active = en_q && !inhibit_q[gi];
            assign sum    = {1'b0, cnt_q} + {1'b0, inc};

            // A software write to this counter wins over the increment,
            // so the lost increment cannot raise an overflow either.
            assign carry[gi]   = active && sum[CNT_W] && !(wr_lo || wr_hi);
            assign cnt_wr[gi]  = wr_lo || wr_hi;
            assign cnt_all[gi] = cnt_q;

            always_comb begin
                cnt_d = cnt_q;
                if (wr_lo) begin
                    cnt_d[31:0] = csr_wdata;
                end else if (wr_hi) begin
                    cnt_d[CNT_W-1:32] = csr_wdata[HI_W-1:0];
                end else if (active) begin
                    cnt_d = sum[CNT_W-1:0];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control, status, shadow and read-response next state
    // -----------------------------------------------------------------------
    always_comb begin
        en_d           = en_q;
        frz_d          = frz_q;
        inhibit_d      = inhibit_q;
        ie_d           = ie_q;
        ovf_d          = ovf_q;
        shadow_d       = shadow_q;
        shadow_tag_d   = shadow_tag_q;
        shadow_valid_d = shadow_valid_q;
        rdata_d        = rdata_q;
        rvalid_d       = csr_re;
        irq_d          = |(ovf_q & ie_q);
        for (int j = 0; j < NUM_CNT; j++) begin
            sel_d[j] = sel_q[j];
        end

        // Freeze: stop everything on the edge that records an overflow.
        if (frz_q && (|carry)) begin
            en_d = 1'b0;
        end

        if (csr_we) begin
            case (csr_addr)
                ADDR_CTRL: begin
                    en_d  = csr_wdata[0];
                    frz_d = csr_wdata[1];
                end
                ADDR_INHIBIT: inhibit_d = csr_wdata[TOT-1:0];
                ADDR_OVF:     ovf_d     = ovf_q & ~csr_wdata[TOT-1:0];
                ADDR_IE:      ie_d      = csr_wdata[TOT-1:0];
                default: ;
            endcase
            for (int j = 0; j < NUM_CNT; j++) begin
                if (csr_addr == 8'(8'h80 + j)) begin
                    sel_d[j] = csr_wdata[7:0];
                end
            end
        end

        // New overflows are OR-ed in after the W1C so a same-edge set wins.
        ovf_d = ovf_d | carry;

        // Read mux sees pre-write, pre-increment state.
        if (csr_re) begin
            rdata_d = '0;
            case (csr_addr)
                ADDR_CTRL:    rdata_d = {30'd0, frz_q, en_q};
                ADDR_INHIBIT: rdata_d = 32'(inhibit_q);
                ADDR_OVF:     rdata_d = 32'(ovf_q);
                ADDR_IE:      rdata_d = 32'(ie_q);
                default: ;
            endcase
            for (int k = 0; k < TOT; k++) begin
                if (csr_addr == 8'(16 + 2 * k)) begin
                    rdata_d        = cnt_all[k][31:0];
                    shadow_d       = cnt_all[k][CNT_W-1:32];
                    shadow_tag_d   = TAG_W'(k);
                    shadow_valid_d = 1'b1;
                end
                if (csr_addr == 8'(17 + 2 * k)) begin
                    if (shadow_valid_q && (shadow_tag_q == TAG_W'(k))) begin
                        rdata_d = 32'(shadow_q);
                    end else begin
                        rdata_d = 32'(cnt_all[k][CNT_W-1:32]);
                    end
                end
            end
            for (int j = 0; j < NUM_CNT; j++) begin
                if (csr_addr == 8'(8'h80 + j)) begin
                    rdata_d = {24'd0, sel_q[j]};
                end
            end
        end

        // A write to a counter makes any shadow of it stale, including one
        // captured by a lo read on this very cycle.
        for (int k = 0; k < TOT; k++) begin
            if (cnt_wr[k] && (shadow_tag_d == TAG_W'(k))) begin
                shadow_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q           <= 1'b0;
            frz_q          <= 1'b0;
            inhibit_q      <= '0;
            ovf_q          <= '0;
            ie_q           <= '0;
            shadow_q       <= '0;
            shadow_tag_q   <= '0;
            shadow_valid_q <= 1'b0;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
            irq_q          <= 1'b0;
            for (int j = 0; j < NUM_CNT; j++) begin
                sel_q[j] <= '0;
            end
        end else begin
            en_q           <= en_d;
            frz_q          <= frz_d;
            inhibit_q      <= inhibit_d;
            ovf_q          <= ovf_d;
            ie_q           <= ie_d;
            shadow_q       <= shadow_d;
            shadow_tag_q   <= shadow_tag_d;
            shadow_valid_q <= shadow_valid_d;
            rdata_q        <= rdata_d;
            rvalid_q       <= rvalid_d;
            irq_q          <= irq_d;
            for (int j = 0; j < NUM_CNT; j++) begin
                sel_q[j] <= sel_d[j];
            end
        end
    end

    assign csr_rdata  = rdata_q;
    assign csr_rvalid = rvalid_q;
    assign ovf_irq    = irq_q;

endmodule

// File: tb/tb_hpm_counter_unit.sv
// ---------------------------------------------------------------------------
// tb_hpm_counter_unit
//
// Directed bench for hpm_counter_unit with default parameters
// (NUM_CNT=4, CNT_W=48, NUM_EVT=32, RET_W=2; counters 0..5, counter k lo at
// 0x10+2k, hi at 0x11+2k). A table of CSR accesses covers the register map,
// then hand-written sequences cover counting, overflow/freeze/interrupt,
// the hi-word shadow, write priority and reset during a read.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_hpm_counter_unit;

    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 48;
    localparam int NUM_EVT = 32;
    localparam int RET_W   = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [RET_W-1:0]   retire_cnt = '0;
    logic [NUM_EVT-1:0] event_vec = '0;
    logic               csr_we = 1'b0;
    logic               csr_re = 1'b0;
    logic [7:0]         csr_addr = '0;
    logic [31:0]        csr_wdata = '0;
    logic [31:0]        csr_rdata;
    logic               csr_rvalid;
    logic               ovf_irq;

    int checks   = 0;
    int failures = 0;

    hpm_counter_unit #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .NUM_EVT (NUM_EVT),
        .RET_W   (RET_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .retire_cnt (retire_cnt),
        .event_vec  (event_vec),
        .csr_we     (csr_we),
        .csr_re     (csr_re),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_rvalid (csr_rvalid),
        .ovf_irq    (ovf_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] data;   // write data, or expected read data
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        $display("wr   addr=0x%02h data=0x%08h", a, d);
    endtask

    // One read transaction; rvalid one cycle later is itself checked.
    task automatic csr_read(input string name, input logic [7:0] a, output logic [31:0] d);
        csr_re   = 1'b1;
        csr_addr = a;
        @(posedge clk);
        #1;
        csr_re = 1'b0;
        check({name, " rvalid"}, 32'(csr_rvalid), 32'd1);
        d = csr_rdata;
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        csr_read(name, a, d);
        check(name, d, exp);
    endtask

    task automatic pulse(input logic [NUM_EVT-1:0] v);
        event_vec = v;
        @(posedge clk);
        #1;
        event_vec = '0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        csr_we     = 1'b0;
        csr_re     = 1'b0;
        event_vec  = '0;
        retire_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs [18];

    initial begin
        logic [31:0] a_val, b_val;

        // Register-map table, applied with EN = 0 so nothing counts.
        vecs[0]  = '{1'b1, 8'h01, 32'h0000_0015, "inhibit wr"};
        vecs[1]  = '{1'b0, 8'h01, 32'h0000_0015, "inhibit rd"};
        vecs[2]  = '{1'b1, 8'h01, 32'hFFFF_FFEA, "inhibit wr wide"};
        vecs[3]  = '{1'b0, 8'h01, 32'h0000_002A, "inhibit rd masked"};
        vecs[4]  = '{1'b1, 8'h03, 32'h0000_003F, "ie wr"};
        vecs[5]  = '{1'b0, 8'h03, 32'h0000_003F, "ie rd"};
        vecs[6]  = '{1'b1, 8'h80, 32'h0000_01AB, "sel0 wr"};
        vecs[7]  = '{1'b0, 8'h80, 32'h0000_00AB, "sel0 rd"};
        vecs[8]  = '{1'b1, 8'h84, 32'h0000_0011, "sel4 unmapped wr"};
        vecs[9]  = '{1'b0, 8'h84, 32'h0000_0000, "sel4 unmapped rd"};
        vecs[10] = '{1'b1, 8'h1A, 32'h1234_5678, "cnt5 lo wr"};
        vecs[11] = '{1'b1, 8'h1B, 32'hFFFF_FFFF, "cnt5 hi wr"};
        vecs[12] = '{1'b0, 8'h1A, 32'h1234_5678, "cnt5 lo rd"};
        vecs[13] = '{1'b0, 8'h1B, 32'h0000_FFFF, "cnt5 hi rd"};
        vecs[14] = '{1'b0, 8'h1C, 32'h0000_0000, "cnt6 unmapped rd"};
        vecs[15] = '{1'b0, 8'h04, 32'h0000_0000, "addr4 unmapped rd"};
        vecs[16] = '{1'b1, 8'h00, 32'h0000_0002, "ctrl frz only wr"};
        vecs[17] = '{1'b0, 8'h00, 32'h0000_0002, "ctrl rd"};

        // ---- reset state ----
        do_reset();
        check("reset rvalid", 32'(csr_rvalid), 32'd0);
        check("reset irq", 32'(ovf_irq), 32'd0);
        check("reset rdata", csr_rdata, 32'd0);
        read_chk("reset ctrl", 8'h00, 32'd0);
        read_chk("reset ovf", 8'h02, 32'd0);
        read_chk("reset cycle lo", 8'h10, 32'd0);
        @(posedge clk);
        #1;
        check("rvalid one-cycle pulse", 32'(csr_rvalid), 32'd0);

        // ---- table ----
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                csr_write(vecs[i].addr, vecs[i].data);
            end else begin
                read_chk(vecs[i].name, vecs[i].addr, vecs[i].data);
            end
        end

        // ---- cycle counter: 100 enabled edges ----
        do_reset();
        csr_write(8'h00, 32'h1);
        repeat (100) @(posedge clk);
        #1;
        read_chk("cycle lo 100", 8'h10, 32'd100);
        read_chk("cycle hi 0", 8'h11, 32'd0);

        // ---- instret and inhibit ----
        do_reset();
        retire_cnt = 2'd3;
        csr_write(8'h00, 32'h1);
        repeat (10) @(posedge clk);
        #1;
        retire_cnt = '0;
        read_chk("instret 30", 8'h12, 32'd30);
        csr_write(8'h01, 32'h2);
        csr_read("cycle before inhibit run", 8'h10, a_val);
        retire_cnt = 2'd3;
        repeat (10) @(posedge clk);
        #1;
        retire_cnt = '0;
        read_chk("instret inhibited", 8'h12, 32'd30);
        csr_read("cycle after inhibit run", 8'h10, b_val);
        check("cycle advanced 12", b_val - a_val, 32'd12);

        // ---- programmable counter event select ----
        do_reset();
        csr_write(8'h80, 32'd5);
        csr_write(8'h00, 32'h1);
        for (int i = 0; i < 11; i++) begin
            pulse((i < 7) ? (32'h1 << 5) : (32'h1 << 6));
        end
        read_chk("cnt2 event5 x7", 8'h14, 32'd7);
        csr_write(8'h80, 32'd40);
        event_vec = '1;
        repeat (5) @(posedge clk);
        #1;
        event_vec = '0;
        read_chk("cnt2 sel out of range", 8'h14, 32'd7);
        read_chk("cnt3 sel0 all-high x5", 8'h16, 32'd5);

        // ---- overflow, freeze, interrupt, W1C ----
        do_reset();
        csr_write(8'h15, 32'h0000_FFFF);
        csr_write(8'h14, 32'hFFFF_FFFE);
        csr_write(8'h03, 32'h4);
        csr_write(8'h80, 32'd5);
        csr_write(8'h00, 32'h3);
        pulse(32'h1 << 5);
        pulse(32'h1 << 5);
        check("irq not yet", 32'(ovf_irq), 32'd0);
        @(posedge clk);
        #1;
        check("irq one cycle later", 32'(ovf_irq), 32'd1);
        read_chk("ovf bit2", 8'h02, 32'h4);
        read_chk("ctrl en frozen", 8'h00, 32'h2);
        read_chk("cnt2 lo wrapped", 8'h14, 32'd0);
        read_chk("cnt2 hi wrapped", 8'h15, 32'd0);
        read_chk("cycle frozen at 2", 8'h10, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        read_chk("cycle still 2", 8'h10, 32'd2);
        csr_write(8'h02, 32'h4);
        check("irq held after w1c edge", 32'(ovf_irq), 32'd1);
        @(posedge clk);
        #1;
        check("irq dropped", 32'(ovf_irq), 32'd0);
        read_chk("ovf cleared", 8'h02, 32'd0);

        // ---- instret overflow with nonzero result ----
        do_reset();
        csr_write(8'h13, 32'h0000_FFFF);
        csr_write(8'h12, 32'hFFFF_FFFF);
        csr_write(8'h00, 32'h1);
        retire_cnt = 2'd3;
        @(posedge clk);
        #1;
        retire_cnt = '0;
        read_chk("instret wrapped to 2", 8'h12, 32'd2);
        read_chk("ovf bit1", 8'h02, 32'h2);
        read_chk("ctrl en kept", 8'h00, 32'h1);

        // ---- hi-word shadow ----
        do_reset();
        csr_write(8'h10, 32'hFFFF_FFFC);
        csr_write(8'h00, 32'h1);
        read_chk("shadow lo", 8'h10, 32'hFFFF_FFFC);
        repeat (6) @(posedge clk);
        #1;
        read_chk("shadow hi consistent", 8'h11, 32'd0);
        read_chk("instret lo retags", 8'h12, 32'd0);
        read_chk("cycle hi live", 8'h11, 32'd1);
        csr_read("cycle lo relatch", 8'h10, a_val);
        csr_write(8'h11, 32'd7);
        read_chk("hi after write invalidates", 8'h11, 32'd7);

        // ---- write priority, write+read, reset during read ----
        do_reset();
        csr_write(8'h80, 32'd5);
        csr_write(8'h00, 32'h1);
        csr_we    = 1'b1;
        csr_addr  = 8'h14;
        csr_wdata = 32'd100;
        event_vec = 32'h1 << 5;
        @(posedge clk);
        #1;
        csr_we    = 1'b0;
        event_vec = '0;
        read_chk("write beats increment", 8'h14, 32'd100);
        csr_we    = 1'b1;
        csr_re    = 1'b1;
        csr_addr  = 8'h14;
        csr_wdata = 32'd55;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        csr_re = 1'b0;
        check("we+re returns pre-write", csr_rdata, 32'd100);
        read_chk("we+re write applied", 8'h14, 32'd55);
        csr_re   = 1'b1;
        csr_addr = 8'h14;
        @(posedge clk);
        #1;
        csr_re = 1'b0;
        reset  = 1'b1;
        #1;
        check("async reset drops rvalid", 32'(csr_rvalid), 32'd0);
        csr_re   = 1'b1;
        csr_addr = 8'h14;
        @(posedge clk);
        #1;
        csr_re = 1'b0;
        check("read during reset no rvalid", 32'(csr_rvalid), 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        read_chk("cnt2 cleared", 8'h14, 32'd0);
        read_chk("sel0 cleared", 8'h80, 32'd0);
        read_chk("ctrl cleared", 8'h00, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hpm_counter_unit.md
Name: hpm_counter_unit

Overview:
- Parametrised hardware performance-monitor unit: fixed cycle and instret counters plus NUM_CNT programmable event counters of CNT_W bits.
- Each programmable counter selects one of NUM_EVT core event lines.
- Software reads and writes the unit over a simple 32-bit CSR bus. Per-counter inhibit, overflow status with interrupt, freeze-on-overflow, and atomic 64-bit reads via a hi-word shadow.
- Sits beside the pipeline's retire stage; event lines come from the pipeline, caches and branch predictor.

Parameters:
NUM_CNT, 4, programmable counters (1..30); counter index 0 = cycle, 1 = instret, 2..NUM_CNT+1 = programmable
CNT_W, 48, counter width (33..64)
NUM_EVT, 32, number of event input lines (1..256)
RET_W, 2, width of per-cycle retire count

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
retire_cnt  in  RET_W  instructions retired this cycle (0..2^RET_W-1)
event_vec  in  NUM_EVT  per-cycle event pulses
csr_we  in  1  write strobe
csr_re  in  1  read strobe
csr_addr  in  8  word address
csr_wdata  in  32  write data
csr_rdata  out  32  read data
csr_rvalid  out  1  read data valid
ovf_irq  out  1  overflow interrupt, registered

Behaviour:
- Reset: all counters, CTRL, INHIBIT, OVF, IE and SEL registers clear to 0. csr_rdata = 0, csr_rvalid = 0, ovf_irq = 0, shadow cleared.
- Register map (word addresses):
  - 0x00 CTRL: bit0 EN (global enable), bit1 FRZ (freeze on overflow).
  - 0x01 INHIBIT[NUM_CNT+1:0].
  - 0x02 OVF[NUM_CNT+1:0], write-1-to-clear.
  - 0x03 IE[NUM_CNT+1:0].
  - 0x10+2k: counter k lo[31:0]. 0x11+2k: counter k hi, zero-extended bits [CNT_W-1:32].
  - 0x80+j: SEL for programmable counter j (8 bits, j = 0..NUM_CNT-1).
  - Unmapped reads return 0; unmapped writes are ignored.
- Counting rule: counter k is active when EN = 1 and INHIBIT[k] = 0.
  - Cycle counter: +1 per active cycle.
  - Instret counter: +retire_cnt, zero-extended to CNT_W.
  - Programmable counter: +1 when event_vec[SEL] = 1. SEL >= NUM_EVT never counts.
- Arithmetic is modulo 2^CNT_W.
- Overflow: if a counter's increment carries out of bit CNT_W-1, OVF[k] is set on the same edge. Instret overflow counts even if the result is nonzero after wrap.
  - If FRZ = 1, EN clears on that same edge, so all counters hold from the next cycle.
  - Simultaneous overflows set every affected bit.
- OVF W1C and a new overflow on the same edge: set wins.
- ovf_irq = |(OVF & IE), registered, so it asserts one cycle after the OVF bit sets.
- CSR write to a counter half replaces that half. Write takes priority over a same-cycle increment (the increment is lost). A write never sets OVF.
- A CSR write to CTRL takes priority over a same-cycle freeze clear.
- Reads: csr_re samples csr_addr. csr_rdata/csr_rvalid are valid exactly 1 cycle later; csr_rvalid is a 1-cycle pulse per csr_re.
  - Read value reflects counter state before any same-cycle increment.
  - Reading lo of counter k latches that counter's hi into the shadow and tags it k.
  - Reading hi of counter k returns the shadow if the tag = k, otherwise live hi.
  - Writing any half of counter k invalidates a shadow tagged k.
- csr_we and csr_re on the same cycle: the write is applied and the read returns the pre-write value.
- Reset mid-operation: all state clears immediately. An in-flight read response is dropped (csr_rvalid = 0).

Test Plan:
- After reset, write CTRL = 1 and run 100 cycles, then read 0x10 -> 100 (±1 for write/read cycle alignment), and 0x11 -> 0.
- With retire_cnt = 3 for 10 cycles and INHIBIT = 0 -> instret lo = 30. Then set INHIBIT bit1 and run 10 more cycles -> instret still 30, cycle counter still advancing.
- Program SEL[0] = 5 and pulse event_vec[5] 7 times, event_vec[6] 4 times -> counter 2 = 7. Then SEL[0] = 40 (NUM_EVT = 32) with all events high -> counter unchanged.
- Write counter 2 hi = 0xFFFF, lo = 0xFFFFFFFE, IE[2] = 1, FRZ = 1, then 2 event pulses -> counter = 0, OVF = 0x4, ovf_irq high 1 cycle later, EN reads 0. W1C OVF -> ovf_irq drops the following cycle.
- Set cycle counter to 0x0000_FFFF_FFFF and read lo then hi, with the carry occurring between the two reads -> the hi/lo pair is consistent (hi = 0 with lo = 0xFFFFFFFx).
- Write counter 2 lo on the same cycle as an event pulse -> the written value is held, no increment. Assert reset during a pending read -> csr_rvalid stays 0 and all registers read 0.
